updown_counter_mod: RTL



---
 rtl/counter_pkg.sv | 23 ++
 rtl/counter_next.sv | 49 ++++
 rtl/updown_counter_mod.sv | 81 ++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package counter_pkg;

    // Boundary behaviour selectors for the next-value logic.
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Ceiling log2, used at elaboration to validate parameter ranges.
    function automatic int unsigned clog2(input longint unsigned value);
        int unsigned     r_bits;
        longint unsigned r_span;
        r_bits = 0;
        r_span = 1;
        for (int i = 0; i < 64; i++) begin
            if (r_span < value) begin
                r_span = r_span << 1;
                r_bits = r_bits + 1;
            end
        end
        return r_bits;
    endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-value calculation: one step up or down with wrap/clamp
// handling. Arithmetic is carried at WIDTH+1 bits so nothing overflows.
module counter_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_VAL = 255,
    parameter int unsigned STEP_W  = 4
) (
    input  logic [WIDTH-1:0]  i_value,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_direction,
    input  logic              i_mode,
    output logic [WIDTH-1:0]  o_next,
    output logic              o_boundary
);

    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MAX_VAL + 1);

    logic [WIDTH:0] w_cur;
    logic [WIDTH:0] w_step;
    logic [WIDTH:0] w_sum;

    assign w_cur  = {1'b0, i_value};
    assign w_step = (WIDTH+1)'(i_step);
    assign w_sum  = w_cur + w_step;

    // Pick the stepped value, folding it back into 0..MAX_VAL when it leaves the range.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_next     = WIDTH'(w_sum);
        o_boundary = 1'b0;
        if (i_direction) begin
            if (w_sum > MAX_EXT) begin
                o_boundary = 1'b1;
                o_next     = (i_mode == MODE_SAT) ? WIDTH'(MAX_EXT) : WIDTH'(w_sum - MOD_EXT);
            end
        end else begin
            if (w_step > w_cur) begin
                o_boundary = 1'b1;
                o_next     = (i_mode == MODE_SAT) ? '0 : WIDTH'(w_cur + MOD_EXT - w_step);
            end else begin
                o_next     = WIDTH'(w_cur - w_step);
            end
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with modulus, step, wrap/saturate mode,
// synchronous load and a registered boundary-event flag.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 255,
    parameter int unsigned STEP_W   = 4,
    parameter int unsigned SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              direction,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  counter_out,
    output logic              boundary,
    output logic              at_max,
    output logic              at_min
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic             MODE    = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

    // Reject parameter sets that cannot be represented or that allow a step
    // larger than the whole count range.
    if (clog2(longint'(MAX_VAL) + 1) > WIDTH) begin : g_bad_max
        $fatal(1, "updown_counter_mod: MAX_VAL does not fit in WIDTH bits");
    end
    if (((longint'(1) << STEP_W) - 1) > longint'(MAX_VAL)) begin : g_bad_step
        $fatal(1, "updown_counter_mod: largest step exceeds MAX_VAL");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_boundary;
    logic [WIDTH-1:0] w_next;
    logic             w_boundary_event;
    logic [WIDTH-1:0] w_load_clamped;

    counter_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP_W  (STEP_W)
    ) u_next (
        .i_value     (r_count),
        .i_step      (step),
        .i_direction (direction),
        .i_mode      (MODE),
        .o_next      (w_next),
        .o_boundary  (w_boundary_event)
    );

    assign w_load_clamped = ({1'b0, load_value} > MAX_EXT) ? MAX_W : load_value;

    // Count register and event flag: reset > load > hold > count.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is just the highest-priority branch of the clocked block.
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all flop updates so every register samples pre-edge values.
            r_count    <= '0;
            r_boundary <= 1'b0;
        end else if (load) begin
            r_count    <= w_load_clamped;
            r_boundary <= 1'b0;
        end else if (!enable) begin
            r_boundary <= 1'b0;
        end else begin
            r_count    <= w_next;
            r_boundary <= w_boundary_event;
        end
    end

    assign counter_out = r_count;
    assign boundary    = r_boundary;
    assign at_max      = (r_count == MAX_W);
    assign at_min      = (r_count == '0);

endmodule
